// File: rtl/sram_mem_controller.sv
// Sequences 32-bit MEM-stage load/store requests onto a 16-bit asynchronous
// SRAM as two half-word accesses (low half first, then high half), holding
// the pipeline frozen through ready=0 while a transaction is in flight.
module sram_mem_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024, // byte address of SRAM word 0
    parameter int          SRAM_AW     = 18,       // half-word address width
    parameter int          WAIT_CYCLES = 2         // cycles per half-word access, >= 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [15:0]        sram_dq_in,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam int            CW       = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        cnt;
    logic                 op_wr;     // latched operation: 1 = store
    logic [15:0]          data_hi;   // latched upper half of the store data
    logic [15:0]          low_half;  // low half of a load, captured at end of LOW
    logic                 req;
    logic                 last;
    logic [SRAM_AW-2:0]   word_idx;

    assign req  = rd_en | wr_en;
    assign last = (cnt == CNT_LAST);

    // Word index of the incoming request; out-of-range addresses wrap.
    assign word_idx = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);

    // State register and per-half wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_nxt;
            if ((state == LOW) || (state == HIGH)) begin
                cnt <= last ? '0 : cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    // Next-state: accept in IDLE, two timed halves, one DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req)  state_nxt = LOW;
            LOW:     if (last) state_nxt = HIGH;
            HIGH:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes and ready, decoded from state, counter and latched operation.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        ready      = 1'b0;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        case (state)
            IDLE: ready = !req;
            LOW, HIGH: begin
                sram_ce_n = 1'b0;
                if (op_wr) begin
                    sram_dq_oe = 1'b1;
                    // WE rises on the final cycle so address/data straddle it.
                    sram_we_n  = last;
                end else begin
                    sram_oe_n  = 1'b0;
                end
            end
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Request latching, SRAM address/data sequencing and load assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_wr       <= 1'b0;
            data_hi     <= '0;
            low_half    <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr     <= wr_en;
                        data_hi   <= write_data[31:16];
                        sram_addr <= {word_idx, 1'b0};
                        if (wr_en) begin
                            sram_dq_out <= write_data[15:0];
                        end
                    end
                end
                LOW: begin
                    if (last) begin
                        sram_addr[0] <= 1'b1;
                        if (op_wr) begin
                            sram_dq_out <= data_hi;
                        end else begin
                            low_half <= sram_dq_in;
                        end
                    end
                end
                HIGH: begin
                    if (last && !op_wr) begin
                        read_data <= {sram_dq_in, low_half};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Sequences the MEM stage's 32-bit load/store requests onto an external 16-bit asynchronous SRAM.
- Each word is moved as two half-word accesses: low half first, then high half.
- Drives `ready` low while a transaction is in flight. The pipeline uses it as a freeze: IF/ID/EXE/MEM registers hold while `ready`=0.
- Sits between the MEM stage and the board SRAM pins, replacing on-chip data memory.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- SRAM_AW, 18: SRAM half-word address width.
- WAIT_CYCLES, 2: clock cycles held per half-word access; minimum 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- wr_en  in  1  store request from MEM stage.
- rd_en  in  1  load request from MEM stage.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (val_Rm).
- read_data  out  32  load result, registered.
- ready  out  1  1 = no transaction pending or one completing this cycle; 0 = freeze pipeline.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_dq_in  in  16  SRAM data bus, read direction.
- sram_dq_out  out  16  SRAM data bus, write direction.
- sram_dq_oe  out  1  1 = drive sram_dq_out onto bus.
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.

Behaviour:
- States: IDLE, LOW, HIGH, DONE.
- Counter `cnt` runs 0..WAIT_CYCLES-1 within LOW and HIGH.
- req = rd_en | wr_en. op = write if wr_en, else read; write wins when both are asserted.
- IDLE:
  - req=0: stay in IDLE.
  - req=1: latch op, address and write_data; go to LOW with cnt=0.
- Mid-transaction changes on the request inputs are ignored.
- ready is combinational: 1 when (IDLE and req=0) or DONE; 0 otherwise, including the IDLE cycle that accepts a request.
- word_idx = (latched address - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits. Out-of-range addresses wrap silently.
- sram_addr = {word_idx, 0} in LOW and {word_idx, 1} in HIGH, stable for the whole state. It holds its last value elsewhere.
- LOW/HIGH common:
  - sram_ce_n=0.
  - cnt increments each cycle.
  - At cnt=WAIT_CYCLES-1, advance LOW→HIGH or HIGH→DONE and reset cnt.
- LOW/HIGH, write:
  - sram_dq_oe=1; sram_dq_out = data[15:0] in LOW, data[31:16] in HIGH.
  - sram_oe_n=1.
  - sram_we_n=0 for cnt < WAIT_CYCLES-1 and 1 on the final cycle, so address/data are stable around the WE rising edge.
- LOW/HIGH, read:
  - sram_oe_n=0, sram_we_n=1, sram_dq_oe=0.
  - At the edge ending the final LOW cycle, capture sram_dq_in into an internal low-half register.
  - At the edge ending the final HIGH cycle, load read_data = {sram_dq_in, low_half}.
- DONE: all strobes inactive; ready=1; unconditional next state IDLE. The pipeline advances on this edge, so the following IDLE sees the next instruction's request.
- Latency: request first seen in IDLE at cycle 0 → ready=0 for cycles 0..2·WAIT_CYCLES → ready=1 in cycle 2·WAIT_CYCLES+1. With defaults: 5 freeze cycles, ready high at cycle 5, read_data valid from cycle 5.
- read_data holds the last completed load; stores never modify it.
- Reset (asynchronous, immediate, including mid-transaction):
  - State IDLE, cnt=0, read_data=0, low_half=0, sram_addr=0, sram_dq_out=0.
  - sram_dq_oe=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1.
  - An interrupted transaction is abandoned; the SRAM is left untouched beyond any half already strobed.
- Outputs in IDLE/DONE: sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0.

Test Plan:
- Reset: assert rst=0 mid-run → all outputs take their reset values within the same cycle; ready=1 with req=0.
- Store: wr_en=1, address=1024, write_data=0x12345678 →
  - sram_addr=0, dq_out=0x5678, we_n low 1 cycle then high;
  - then sram_addr=1, dq_out=0x1234;
  - ready=0 for 5 cycles, 1 on the 6th.
- Load: rd_en=1, address=1032, SRAM model returning 0xBEEF @4 and 0xCAFE @5 → sram_addr 4 then 5, oe_n low; read_data=0xCAFEBEEF when ready rises.
- Write priority / input isolation: rd_en=wr_en=1 → write cycle (we_n pulses, read_data unchanged). Changing address and write_data during LOW → SRAM still sees the originally latched values.
- Back-to-back: store 0xA5A55A5A @1028, then load @1028 → read_data=0xA5A55A5A; the IDLE cycle between them shows ready=0 (accept).
- Reset mid-op: rst=0 during HIGH of a store → strobes release immediately; after release, a fresh load completes in 6 cycles.
